// File: rtl/hicore_disp_q_if.sv
// Dispatch stage bus bundle: decode->execute upstream handshake plus the
// per-unit issue channels.
//   master : dispatch side (accepts decode entries, drives unit issue)
//   slave  : environment side (drives decode entries, accepts unit issue)
// Signals:
//   i_de2ex_valid/ready/info/sel/rd_need/rd_idx : upstream entry handshake
//   o_unit_valid/ready/info                     : per-unit issue channels
interface hicore_disp_q_if #(
  parameter int unsigned NUM_UNIT = 5,
  parameter int unsigned INFO_W   = 64,
  parameter int unsigned RFIDX_W  = 5
);
  logic                i_de2ex_valid;
  logic                i_de2ex_ready;
  logic [INFO_W-1:0]   i_de2ex_info;
  logic [NUM_UNIT-1:0] i_de2ex_sel;
  logic                i_de2ex_rd_need;
  logic [RFIDX_W-1:0]  i_de2ex_rd_idx;
  logic [NUM_UNIT-1:0] o_unit_valid;
  logic [NUM_UNIT-1:0] o_unit_ready;
  logic [INFO_W-1:0]   o_unit_info;

  modport master (
    input  i_de2ex_valid, i_de2ex_info, i_de2ex_sel, i_de2ex_rd_need, i_de2ex_rd_idx,
    input  o_unit_ready,
    output i_de2ex_ready, o_unit_valid, o_unit_info
  );

  modport slave (
    output i_de2ex_valid, i_de2ex_info, i_de2ex_sel, i_de2ex_rd_need, i_de2ex_rd_idx,
    output o_unit_ready,
    input  i_de2ex_ready, o_unit_valid, o_unit_info
  );
endinterface

// File: rtl/hicore_disp_q.sv
// Buffered dispatch stage: FIFO of decoded entries, head issued to the one
// execute unit named by its one-hot select.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   bus (master)     : upstream handshake and per-unit issue channels
//   i_flush          : synchronous drop of all buffered entries
//   o_nop_fire       : head with empty select retired this cycle
//   i_chk_idx        : register hazard query index
//   o_chk_hit        : some buffered entry writes i_chk_idx
//   ex_rd_need/idx   : head destination register info
//   o_count          : occupied entries
//   o_sel_err        : sticky, a multi-hot select reached the head
module hicore_disp_q #(
  parameter int unsigned NUM_UNIT = 5,
  parameter int unsigned INFO_W   = 64,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RFIDX_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  hicore_disp_q_if.master    bus,
  input  logic               i_flush,
  output logic               o_nop_fire,
  input  logic [RFIDX_W-1:0] i_chk_idx,
  output logic               o_chk_hit,
  output logic               ex_rd_need,
  output logic [RFIDX_W-1:0] ex_rd_idx,
  output logic [3:0]         o_count,
  output logic               o_sel_err
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DepthC = 4'(DEPTH);

  logic [INFO_W-1:0]   info_q    [DEPTH];
  logic [NUM_UNIT-1:0] sel_q     [DEPTH];
  logic                rd_need_q [DEPTH];
  logic [RFIDX_W-1:0]  rd_idx_q  [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]       count_q, count_d;
  logic             sel_err_q, sel_err_d;

  logic                head_valid, push, pop, multi_hot;
  logic [NUM_UNIT-1:0] head_sel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign head_valid = (count_q != 4'd0);
  assign head_sel   = sel_q[rptr_q];
  assign multi_hot  = |(head_sel & (head_sel - 1'b1));

  // Readiness looks only at registered occupancy, so a full FIFO refuses a
  // push even while it pops; this keeps o_unit_ready off the upstream path.
  assign bus.i_de2ex_ready = (count_q < DepthC) & ~i_flush;
  assign push = bus.i_de2ex_valid & bus.i_de2ex_ready;
  assign pop  = head_valid & ~i_flush & ((head_sel == '0) | (|(head_sel & bus.o_unit_ready)));

  assign bus.o_unit_valid = head_valid ? head_sel : '0;
  assign bus.o_unit_info  = head_valid ? info_q[rptr_q] : '0;
  assign o_nop_fire       = head_valid & (head_sel == '0);
  assign ex_rd_need       = head_valid & rd_need_q[rptr_q];
  assign ex_rd_idx        = head_valid ? rd_idx_q[rptr_q] : '0;
  assign o_count          = count_q;
  assign o_sel_err        = sel_err_q;

  // Hazard lookup: entry i is occupied when its distance from the read
  // pointer is below the count. The entry being pushed is not yet visible.
  always_comb begin
    o_chk_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      int off;
      off = i - int'(rptr_q);
      if (off < 0) off = off + int'(DEPTH);
      if ((off < int'(count_q)) && rd_need_q[i] && (rd_idx_q[i] == i_chk_idx)) begin
        o_chk_hit = 1'b1;
      end
    end
  end

  always_comb begin
    count_d   = count_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    sel_err_d = sel_err_q | (head_valid & multi_hot);
    if (i_flush) begin
      count_d = 4'd0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop)      count_d = count_q + 4'd1;
      else if (!push && pop) count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 4'd0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Payload storage needs no reset: every read is qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      info_q[wptr_q]    <= bus.i_de2ex_info;
      sel_q[wptr_q]     <= bus.i_de2ex_sel;
      rd_need_q[wptr_q] <= bus.i_de2ex_rd_need;
      rd_idx_q[wptr_q]  <= bus.i_de2ex_rd_idx;
    end
  end
endmodule
